// File: rtl/arb_pkg.sv
// Shared types and default widths for the dual-issue data-memory arbiter.
package arb_pkg;

  localparam int unsigned ARB_AW = 9;
  localparam int unsigned ARB_DW = 16;
  localparam int unsigned ARB_CW = 16;

  typedef enum logic {
    IDLE,
    SERVE_P1
  } arb_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset and increment enable.
module sat_counter #(
  parameter int unsigned CW = 16
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_inc,
  output logic [CW-1:0] o_count
);

  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;

  always_comb begin
    w_count_next = r_count;
    if (i_inc && (r_count != {CW{1'b1}})) begin
      w_count_next = r_count + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/dual_issue_mem_arbiter.sv
// Serializes p0/p1 accesses onto one single-port data RAM, p0 first in program order.
// Optional ARB_STLD_FWD_EN: same-address p0 STR + p1 LDR is granted together with store forwarding.
module dual_issue_mem_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned AW = ARB_AW,
  parameter int unsigned DW = ARB_DW,
  parameter int unsigned CW = ARB_CW
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_p0_req,
  input  logic          i_p0_write,
  input  logic [AW-1:0] i_p0_addr,
  input  logic [DW-1:0] i_p0_wdata,
  input  logic          i_p1_req,
  input  logic          i_p1_write,
  input  logic [AW-1:0] i_p1_addr,
  input  logic [DW-1:0] i_p1_wdata,
  output logic          o_p0_gnt,
  output logic          o_p1_gnt,
  output logic          o_p0_rvalid,
  output logic          o_p1_rvalid,
  output logic [DW-1:0] o_p0_rdata,
  output logic [DW-1:0] o_p1_rdata,
  output logic          o_stall,
  output logic [AW-1:0] o_mem_addr,
  output logic          o_mem_write,
  output logic [DW-1:0] o_mem_din,
  input  logic [DW-1:0] i_mem_dout,
  output logic [CW-1:0] o_conflict_cnt
);

  arb_state_t    r_state;
  arb_state_t    w_state_next;
  logic          w_p0_gnt;
  logic          w_p1_gnt;
  logic          w_stall;
  logic          w_conflict;
  logic          w_fwd;
  logic          r_p0_rvalid;
  logic          r_p1_rvalid;
  logic          r_p1_fwd;
  logic [DW-1:0] r_fwd_data;
  logic [DW-1:0] r_p0_rdata;
  logic [DW-1:0] r_p1_rdata;

`ifdef ARB_STLD_FWD_EN
  assign w_fwd = i_p0_req && i_p0_write && i_p1_req && !i_p1_write && (i_p0_addr == i_p1_addr);
`else
  assign w_fwd = 1'b0;
`endif

  // Everything is gated by reset so a pending p1 store is never issued in the reset cycle.
  always_comb begin
    w_state_next = r_state;
    w_p0_gnt     = 1'b0;
    w_p1_gnt     = 1'b0;
    w_stall      = 1'b0;
    w_conflict   = 1'b0;
    if (!i_reset) begin
      unique case (r_state)
        IDLE: begin
          if (i_p0_req && i_p1_req) begin
            w_p0_gnt = 1'b1;
            if (w_fwd) begin
              w_p1_gnt = 1'b1;
            end else begin
              w_stall      = 1'b1;
              w_conflict   = 1'b1;
              w_state_next = SERVE_P1;
            end
          end else begin
            w_p0_gnt = i_p0_req;
            w_p1_gnt = i_p1_req;
          end
        end
        SERVE_P1: begin
          w_p1_gnt     = i_p1_req;
          w_state_next = IDLE;
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  // In the forwarding case p0 owns the RAM port; p1 is served from r_fwd_data.
  always_comb begin
    o_mem_addr  = '0;
    o_mem_write = 1'b0;
    o_mem_din   = '0;
    if (w_p0_gnt) begin
      o_mem_addr  = i_p0_addr;
      o_mem_write = i_p0_write;
      o_mem_din   = i_p0_wdata;
    end else if (w_p1_gnt) begin
      o_mem_addr  = i_p1_addr;
      o_mem_write = i_p1_write;
      o_mem_din   = i_p1_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_p0_rvalid <= 1'b0;
      r_p1_rvalid <= 1'b0;
      r_p1_fwd    <= 1'b0;
      r_fwd_data  <= '0;
      r_p0_rdata  <= '0;
      r_p1_rdata  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_p0_rvalid <= w_p0_gnt && !i_p0_write;
      r_p1_rvalid <= w_p1_gnt && !i_p1_write;
      r_p1_fwd    <= w_fwd;
      if (w_fwd) begin
        r_fwd_data <= i_p0_wdata;
      end
      r_p0_rdata  <= o_p0_rdata;
      r_p1_rdata  <= o_p1_rdata;
    end
  end

  assign o_p0_rdata = r_p0_rvalid ? i_mem_dout : r_p0_rdata;
  assign o_p1_rdata = r_p1_rvalid ? (r_p1_fwd ? r_fwd_data : i_mem_dout) : r_p1_rdata;

  assign o_p0_gnt    = w_p0_gnt;
  assign o_p1_gnt    = w_p1_gnt;
  assign o_p0_rvalid = r_p0_rvalid;
  assign o_p1_rvalid = r_p1_rvalid;
  assign o_stall     = w_stall;

  sat_counter #(
    .CW(CW)
  ) u_conflict_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_inc   (w_conflict),
    .o_count (o_conflict_cnt)
  );

endmodule

// File: tb/tb_dual_issue_mem_arbiter.sv
// Directed bench for dual_issue_mem_arbiter with a behavioural RAM and per-pipe read scoreboards.
module tb_dual_issue_mem_arbiter;
  import arb_pkg::*;

  localparam int unsigned AW = ARB_AW;
  localparam int unsigned DW = ARB_DW;
  localparam int unsigned CW = ARB_CW;

  logic          clk = 1'b0;
  logic          reset;
  logic          p0_req, p0_write, p1_req, p1_write;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, stall, mem_write;
  logic [DW-1:0] p0_rdata, p1_rdata, mem_din, mem_dout;
  logic [AW-1:0] mem_addr;
  logic [CW-1:0] conflict_cnt;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] q0 [$];
  logic [DW-1:0] q1 [$];
  logic [CW-1:0] exp_cnt;
  int            checks   = 0;
  int            failures = 0;

  always #5 clk = ~clk;

  dual_issue_mem_arbiter dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_p0_req       (p0_req),
    .i_p0_write     (p0_write),
    .i_p0_addr      (p0_addr),
    .i_p0_wdata     (p0_wdata),
    .i_p1_req       (p1_req),
    .i_p1_write     (p1_write),
    .i_p1_addr      (p1_addr),
    .i_p1_wdata     (p1_wdata),
    .o_p0_gnt       (p0_gnt),
    .o_p1_gnt       (p1_gnt),
    .o_p0_rvalid    (p0_rvalid),
    .o_p1_rvalid    (p1_rvalid),
    .o_p0_rdata     (p0_rdata),
    .o_p1_rdata     (p1_rdata),
    .o_stall        (stall),
    .o_mem_addr     (mem_addr),
    .o_mem_write    (mem_write),
    .o_mem_din      (mem_din),
    .i_mem_dout     (mem_dout),
    .o_conflict_cnt (conflict_cnt)
  );

  // Single-port RAM, read data one cycle after the address.
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_din;
    mem_dout <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every rvalid pops the oldest expected load value of that pipe.
  always @(negedge clk) begin
    if (p0_rvalid === 1'b1) begin
      if (q0.size() == 0) chk("p0_rvalid_unexpected", {31'd0, p0_rvalid}, 32'd0);
      else chk("p0_rdata", {16'd0, p0_rdata}, {16'd0, q0.pop_front()});
    end
    if (p1_rvalid === 1'b1) begin
      if (q1.size() == 0) chk("p1_rvalid_unexpected", {31'd0, p1_rvalid}, 32'd0);
      else chk("p1_rdata", {16'd0, p1_rdata}, {16'd0, q1.pop_front()});
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_reqs(input logic r0, input logic w0, input logic [AW-1:0] a0,
                          input logic [DW-1:0] d0, input logic r1, input logic w1,
                          input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    p0_req = r0; p0_write = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_write = w1; p1_addr = a1; p1_wdata = d1;
  endtask

  task automatic idle_reqs();
    set_reqs(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    reset = 1'b1;
    idle_reqs();
    exp_cnt = '0;
    mem[9'h004] <= 16'hABCD;
    mem[9'h008] <= 16'h0808;
    mem[9'h010] <= 16'h5A5A;
    mem[9'h020] <= 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_p0_gnt", {31'd0, p0_gnt}, 32'd0);
    chk("rst_p1_gnt", {31'd0, p1_gnt}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("rst_mem_addr", {23'd0, mem_addr}, 32'd0);
    chk("rst_rvalid", {30'd0, p0_rvalid, p1_rvalid}, 32'd0);
    chk("rst_rdata", {p0_rdata, p1_rdata}, 32'd0);
    chk("rst_cnt", {16'd0, conflict_cnt}, 32'd0);
    next_cycle();
    reset = 1'b0;

    // Single p0 load.
    set_reqs(1'b1, 1'b0, 9'h004, '0, 1'b0, 1'b0, '0, '0);
    q0.push_back(16'hABCD);
    @(negedge clk);
    chk("t1_p0_gnt", {31'd0, p0_gnt}, 32'd1);
    chk("t1_p1_gnt", {31'd0, p1_gnt}, 32'd0);
    chk("t1_stall", {31'd0, stall}, 32'd0);
    chk("t1_mem_addr", {23'd0, mem_addr}, 32'h004);
    chk("t1_mem_write", {31'd0, mem_write}, 32'd0);
    next_cycle();
    idle_reqs();
    @(negedge clk);
    chk("t1_p0_rvalid", {31'd0, p0_rvalid}, 32'd1);

    // p0 STR 0x004 + p1 LDR 0x004.
    next_cycle();
    set_reqs(1'b1, 1'b1, 9'h004, 16'h1234, 1'b1, 1'b0, 9'h004, '0);
    q1.push_back(16'h1234);
    @(negedge clk);
    chk("t2_p0_gnt", {31'd0, p0_gnt}, 32'd1);
    chk("t2_mem_write", {31'd0, mem_write}, 32'd1);
    chk("t2_mem_addr", {23'd0, mem_addr}, 32'h004);
    chk("t2_mem_din", {16'd0, mem_din}, 32'h1234);
`ifdef ARB_STLD_FWD_EN
    chk("t2_p1_gnt_c0", {31'd0, p1_gnt}, 32'd1);
    chk("t2_stall_c0", {31'd0, stall}, 32'd0);
`else
    chk("t2_p1_gnt_c0", {31'd0, p1_gnt}, 32'd0);
    chk("t2_stall_c0", {31'd0, stall}, 32'd1);
    exp_cnt = exp_cnt + 1'b1;
    next_cycle();
    @(negedge clk);
    chk("t2_p1_gnt_c1", {31'd0, p1_gnt}, 32'd1);
    chk("t2_p0_gnt_c1", {31'd0, p0_gnt}, 32'd0);
    chk("t2_stall_c1", {31'd0, stall}, 32'd0);
    chk("t2_mem_write_c1", {31'd0, mem_write}, 32'd0);
`endif
    next_cycle();
    idle_reqs();
    @(negedge clk);
    chk("t2_p1_rvalid", {31'd0, p1_rvalid}, 32'd1);
    chk("t2_cnt", {16'd0, conflict_cnt}, {16'd0, exp_cnt});
    chk("t2_mem4", {16'd0, mem[9'h004]}, 32'h1234);

    // p0 LDR 0x010 + p1 STR 0x020: always serialized.
    next_cycle();
    set_reqs(1'b1, 1'b0, 9'h010, '0, 1'b1, 1'b1, 9'h020, 16'hBEEF);
    q0.push_back(16'h5A5A);
    exp_cnt = exp_cnt + 1'b1;
    @(negedge clk);
    chk("t3_p0_gnt", {31'd0, p0_gnt}, 32'd1);
    chk("t3_stall", {31'd0, stall}, 32'd1);
    chk("t3_mem_addr_c0", {23'd0, mem_addr}, 32'h010);
    next_cycle();
    @(negedge clk);
    chk("t3_p1_gnt", {31'd0, p1_gnt}, 32'd1);
    chk("t3_mem_write", {31'd0, mem_write}, 32'd1);
    chk("t3_mem_addr_c1", {23'd0, mem_addr}, 32'h020);
    chk("t3_mem_din", {16'd0, mem_din}, 32'hBEEF);
    next_cycle();
    idle_reqs();
    @(negedge clk);
    chk("t3_mem20", {16'd0, mem[9'h020]}, 32'hBEEF);
    chk("t3_p0_rdata_hold", {16'd0, p0_rdata}, 32'h5A5A);
    chk("t3_p1_no_rvalid", {31'd0, p1_rvalid}, 32'd0);
    chk("t3_cnt", {16'd0, conflict_cnt}, {16'd0, exp_cnt});

    // Reset while serving the deferred p1 store.
    next_cycle();
    set_reqs(1'b1, 1'b0, 9'h008, '0, 1'b1, 1'b1, 9'h008, 16'hDEAD);
    q0.push_back(16'h0808);
    @(negedge clk);
    chk("t4_stall", {31'd0, stall}, 32'd1);
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    chk("t4_rst_p1_gnt", {31'd0, p1_gnt}, 32'd0);
    chk("t4_rst_mem_write", {31'd0, mem_write}, 32'd0);
    next_cycle();
    reset = 1'b0;
    idle_reqs();
    exp_cnt = '0;
    @(negedge clk);
    chk("t4_mem8", {16'd0, mem[9'h008]}, 32'h0808);
    chk("t4_gnt", {30'd0, p0_gnt, p1_gnt}, 32'd0);
    chk("t4_stall_after", {31'd0, stall}, 32'd0);
    chk("t4_rdata", {p0_rdata, p1_rdata}, 32'd0);
    chk("t4_cnt", {16'd0, conflict_cnt}, 32'd0);
    next_cycle();
    set_reqs(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 9'h008, '0);
    q1.push_back(16'h0808);
    @(negedge clk);
    chk("t4_idle_p1_gnt", {31'd0, p1_gnt}, 32'd1);
    chk("t4_idle_stall", {31'd0, stall}, 32'd0);
    next_cycle();
    idle_reqs();
    @(negedge clk);

    // Saturation: preset the counter near the top, then three conflicts.
    next_cycle();
    force dut.u_conflict_cnt.r_count = 16'hFFFE;
    next_cycle();
    release dut.u_conflict_cnt.r_count;
    @(negedge clk);
    exp_cnt = 16'hFFFE;
    chk("t5_preset", {16'd0, conflict_cnt}, {16'd0, exp_cnt});
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      set_reqs(1'b1, 1'b0, 9'h010, '0, 1'b1, 1'b0, 9'h004, '0);
      q0.push_back(16'h5A5A);
      q1.push_back(16'h1234);
      @(negedge clk);
      chk("t5_stall", {31'd0, stall}, 32'd1);
      next_cycle();
      @(negedge clk);
      chk("t5_p1_gnt", {31'd0, p1_gnt}, 32'd1);
      next_cycle();
      idle_reqs();
      if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 1'b1;
      @(negedge clk);
      chk("t5_cnt", {16'd0, conflict_cnt}, {16'd0, exp_cnt});
    end

    next_cycle();
    @(negedge clk);
    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
